tnoc_weighted_round_robin_arbiter: RTL and testbench

//  Weighted round-robin arbiter for router output ports and virtual-channel muxes.

---
 rtl/tnoc_weighted_round_robin_arbiter_if.sv | 39 +++
 rtl/tnoc_weighted_round_robin_arbiter.sv | 135 +++++++++++++
 tb/tb_tnoc_weighted_round_robin_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tnoc_weighted_round_robin_arbiter_if.sv
// Request/grant bundle between requesters and the weighted round-robin arbiter.
//   i_request      per-requester request
//   i_weight       per-requester weight, requester i at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]
//   i_free         release by the current holder (only the granted bit matters)
//   o_grant        one-hot (or zero) grant
//   o_grant_index  binary index of o_grant, 0 when no grant
//   o_busy         a grant is currently being held
// Modports: slave = arbiter side, master = requester side.
interface tnoc_weighted_round_robin_arbiter_if #(
  parameter int unsigned REQUESTS     = 2,
  parameter int unsigned WEIGHT_WIDTH = 4
);
  localparam int unsigned INDEX_WIDTH = $clog2(REQUESTS);

  logic [REQUESTS-1:0]              i_request;
  logic [REQUESTS*WEIGHT_WIDTH-1:0] i_weight;
  logic [REQUESTS-1:0]              i_free;
  logic [REQUESTS-1:0]              o_grant;
  logic [INDEX_WIDTH-1:0]           o_grant_index;
  logic                             o_busy;

  modport slave (
    input  i_request,
    input  i_weight,
    input  i_free,
    output o_grant,
    output o_grant_index,
    output o_busy
  );

  modport master (
    output i_request,
    output i_weight,
    output i_free,
    input  o_grant,
    input  o_grant_index,
    input  o_busy
  );
endinterface

// File: rtl/tnoc_weighted_round_robin_arbiter.sv
// Weighted round-robin arbiter. The current owner keeps winning while it requests
// and still has credit; otherwise the grant rotates to the next requester after the
// owner (owner checked last) and credit is reloaded from that requester's weight.
// With KEEP_RESULT=1 a grant is held until the holder asserts its free bit.
// Ports:
//   clk     clock
//   rst_n   asynchronous active-low reset
//   arb_if  slave side of the request/weight/free/grant/busy bundle
module tnoc_weighted_round_robin_arbiter #(
  parameter int unsigned REQUESTS     = 2,
  parameter int unsigned WEIGHT_WIDTH = 4,
  parameter bit          KEEP_RESULT  = 1'b1
) (
  input logic                            clk,
  input logic                            rst_n,
  tnoc_weighted_round_robin_arbiter_if.slave arb_if
);

  localparam int unsigned INDEX_WIDTH = $clog2(REQUESTS);
  typedef logic [INDEX_WIDTH-1:0]  index_t;
  typedef logic [WEIGHT_WIDTH-1:0] weight_t;

  logic [REQUESTS-1:0] owner_q, owner_d;
  weight_t             credit_q, credit_d;
  logic                busy_q, busy_d;

  weight_t             weight_array [REQUESTS];
  index_t              owner_index;
  index_t              rotate_index;
  logic                rotate_found;
  logic                keep_owner;
  index_t              winner_index;
  logic                grab;
  logic                free;
  weight_t             reload;

  // (base + offset) mod REQUESTS, with offset <= REQUESTS
  function automatic index_t wrap_add(index_t base, int unsigned offset);
    int unsigned sum;
    sum = 32'(base) + offset;
    if (sum >= REQUESTS) begin
      sum = sum - REQUESTS;
    end
    return index_t'(sum);
  endfunction

  always_comb begin
    for (int i = 0; i < REQUESTS; i++) begin
      weight_array[i] = arb_if.i_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end
  end

  always_comb begin
    owner_index = '0;
    for (int i = 0; i < REQUESTS; i++) begin
      if (owner_q[i]) begin
        owner_index = index_t'(i);
      end
    end
  end

  // Scan owner+1 .. owner so the owner itself has lowest priority on rotation.
  always_comb begin
    rotate_found = 1'b0;
    rotate_index = owner_index;
    for (int unsigned k = 1; k <= REQUESTS; k++) begin
      if (!rotate_found && arb_if.i_request[wrap_add(owner_index, k)]) begin
        rotate_found = 1'b1;
        rotate_index = wrap_add(owner_index, k);
      end
    end
  end

  assign keep_owner   = arb_if.i_request[owner_index] && (credit_q != '0);
  assign winner_index = keep_owner ? owner_index : rotate_index;
  assign grab         = (|arb_if.i_request) && (!KEEP_RESULT || !busy_q);
  // Weight 0 behaves like weight 1: one round, no extra credit.
  assign reload       = (weight_array[rotate_index] == '0) ? '0
                                                           : weight_array[rotate_index] -
                                                             WEIGHT_WIDTH'(1);

  always_comb begin
    arb_if.o_grant       = '0;
    arb_if.o_grant_index = '0;
    if (rst_n) begin
      if (grab) begin
        arb_if.o_grant       = REQUESTS'(1) << winner_index;
        arb_if.o_grant_index = winner_index;
      end else if (busy_q) begin
        arb_if.o_grant       = owner_q;
        arb_if.o_grant_index = owner_index;
      end
    end
  end

  assign arb_if.o_busy = busy_q;
  assign free          = |(arb_if.i_free & arb_if.o_grant);

  always_comb begin
    owner_d  = owner_q;
    credit_d = credit_q;
    busy_d   = busy_q;
    if (grab) begin
      if (keep_owner) begin
        credit_d = credit_q - WEIGHT_WIDTH'(1);
      end else begin
        owner_d  = REQUESTS'(1) << rotate_index;
        credit_d = reload;
      end
    end
    if (KEEP_RESULT) begin
      // Free wins over grab, so a single-cycle packet never sets busy.
      if (free) begin
        busy_d = 1'b0;
      end else if (grab) begin
        busy_d = 1'b1;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q  <= REQUESTS'(1) << (REQUESTS - 1);
      credit_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      credit_q <= credit_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: tb/tb_tnoc_weighted_round_robin_arbiter.sv
// Bench for the weighted round-robin arbiter: directed vector table, hand-written
// reset-while-busy sequence, then randomized traffic against a behavioural model.
module tb_tnoc_weighted_round_robin_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // a: 4 requesters, re-arbitrate every cycle; b: 2 requesters, same; c: 4, hold grant
  tnoc_weighted_round_robin_arbiter_if #(.REQUESTS(4), .WEIGHT_WIDTH(4)) if_a ();
  tnoc_weighted_round_robin_arbiter_if #(.REQUESTS(2), .WEIGHT_WIDTH(4)) if_b ();
  tnoc_weighted_round_robin_arbiter_if #(.REQUESTS(4), .WEIGHT_WIDTH(4)) if_c ();

  tnoc_weighted_round_robin_arbiter #(.REQUESTS(4), .WEIGHT_WIDTH(4), .KEEP_RESULT(1'b0)) u_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .arb_if (if_a)
  );
  tnoc_weighted_round_robin_arbiter #(.REQUESTS(2), .WEIGHT_WIDTH(4), .KEEP_RESULT(1'b0)) u_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .arb_if (if_b)
  );
  tnoc_weighted_round_robin_arbiter #(.REQUESTS(4), .WEIGHT_WIDTH(4), .KEEP_RESULT(1'b1)) u_c (
    .clk    (clk),
    .rst_n  (rst_n),
    .arb_if (if_c)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         dut;
    string      name;
    logic [3:0] req;
    logic [15:0] weight;
    logic [3:0] free;
    logic [3:0] exp_grant;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model state, slot 0 mirrors u_a and slot 1 mirrors u_c.
  int m_owner  [2];
  int m_credit [2];
  bit m_busy   [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] idx_of(input logic [3:0] g);
    logic [31:0] r;
    r = 0;
    for (int i = 0; i < 4; i++) begin
      if (g[i]) r = i;
    end
    return r;
  endfunction

  function automatic vec_t mk(input int dut, input string nm, input logic [3:0] req,
                              input logic [15:0] wt, input logic [3:0] fr,
                              input logic [3:0] eg, input logic eb);
    vec_t v;
    v.dut = dut; v.name = nm; v.req = req; v.weight = wt; v.free = fr;
    v.exp_grant = eg; v.exp_busy = eb;
    return v;
  endfunction

  task automatic idle_all();
    if_a.i_request = '0; if_a.i_free = '0;
    if_b.i_request = '0; if_b.i_free = '0;
    if_c.i_request = '0; if_c.i_free = '0;
  endtask

  // Rules: owner with credit keeps winning; else first requester after the owner
  // (wrapping, owner last) wins and credit becomes max(weight,1)-1.
  task automatic model_step(input int d, input bit keep, input logic [3:0] req,
                            input logic [15:0] wt, input logic [3:0] fr,
                            output logic [3:0] eg, output logic eb);
    bit grab;
    bit found;
    int win;
    int w;
    eb    = m_busy[d];
    eg    = '0;
    grab  = (req != 0) && (!keep || !m_busy[d]);
    win   = m_owner[d];
    found = 1'b0;
    if (grab) begin
      if (req[m_owner[d]] && m_credit[d] > 0) begin
        m_credit[d] = m_credit[d] - 1;
      end else begin
        for (int k = 1; k <= 4; k++) begin
          int i;
          i = (m_owner[d] + k) % 4;
          if (!found && req[i]) begin
            found = 1'b1;
            win   = i;
          end
        end
        w           = int'(wt[win*4 +: 4]);
        m_owner[d]  = win;
        m_credit[d] = (w == 0) ? 0 : w - 1;
      end
      eg = 4'b0001 << win;
    end else if (m_busy[d]) begin
      eg = 4'b0001 << m_owner[d];
    end
    if (keep) begin
      if ((fr & eg) != 0) m_busy[d] = 1'b0;
      else if (grab)      m_busy[d] = 1'b1;
    end
  endtask

  initial begin
    logic [3:0] act_g;
    logic       act_b;
    logic [31:0] act_i;
    logic [3:0] eg;
    logic       eb;
    logic [3:0] r;
    logic [3:0] f;

    // Test 1: all weights 1, plain rotation
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, "rot", 4'b1111, 16'h1111, 4'b0000, 4'b0001 << (i % 4), 1'b0));
    // Test 3: weight 0 on req2 behaves like weight 1
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, "w0", 4'b1111, 16'h1011, 4'b0000, 4'b0001 << (i % 4), 1'b0));
    // Test 2: w0=3, w1=1
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, "w31", 4'b0011, 16'h0013, 4'b0000,
                        ((i % 4) == 3) ? 4'b0010 : 4'b0001, 1'b0));
    // Weight change only takes effect on the next rotation onto that requester
    vecs.push_back(mk(1, "wchg", 4'b0011, 16'h0012, 4'b0000, 4'b0001, 1'b0));
    vecs.push_back(mk(1, "wchg", 4'b0011, 16'h0014, 4'b0000, 4'b0001, 1'b0));
    vecs.push_back(mk(1, "wchg", 4'b0011, 16'h0014, 4'b0000, 4'b0010, 1'b0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, "wchg", 4'b0011, 16'h0014, 4'b0000, 4'b0001, 1'b0));
    vecs.push_back(mk(1, "wchg", 4'b0011, 16'h0014, 4'b0000, 4'b0010, 1'b0));
    // Test 4: hold grant on req1, free of a non-holder is ignored
    vecs.push_back(mk(2, "hold", 4'b0010, 16'h1111, 4'b0000, 4'b0010, 1'b0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(2, "hold", 4'b1111, 16'h1111, (i % 2) ? 4'b1000 : 4'b0000,
                        4'b0010, 1'b1));
    vecs.push_back(mk(2, "hold", 4'b1111, 16'h1111, 4'b0010, 4'b0010, 1'b1));
    vecs.push_back(mk(2, "hold", 4'b1111, 16'h1111, 4'b0000, 4'b0100, 1'b0));
    vecs.push_back(mk(2, "hold", 4'b1111, 16'h1111, 4'b0100, 4'b0100, 1'b1));
    // Test 5: one-cycle packet, then dropped request does not release the grant
    vecs.push_back(mk(2, "one", 4'b0001, 16'h1111, 4'b0001, 4'b0001, 1'b0));
    vecs.push_back(mk(2, "one", 4'b0001, 16'h1111, 4'b0000, 4'b0001, 1'b0));
    vecs.push_back(mk(2, "one", 4'b0000, 16'h1111, 4'b0000, 4'b0001, 1'b1));
    vecs.push_back(mk(2, "one", 4'b0000, 16'h1111, 4'b0001, 4'b0001, 1'b1));
    vecs.push_back(mk(2, "one", 4'b0000, 16'h1111, 4'b0000, 4'b0000, 1'b0));

    // Reset: outputs quiet even with everything requesting
    if_a.i_weight = 16'h1111; if_b.i_weight = 8'h11; if_c.i_weight = 16'h1111;
    if_a.i_request = 4'b1111; if_b.i_request = 2'b11; if_c.i_request = 4'b1111;
    if_a.i_free = '0; if_b.i_free = '0; if_c.i_free = '0;
    #3;
    check("rst_grant_a", 32'(if_a.o_grant), 0);
    check("rst_grant_b", 32'(if_b.o_grant), 0);
    check("rst_grant_c", 32'(if_c.o_grant), 0);
    check("rst_busy_c", 32'(if_c.o_busy), 0);
    check("rst_index_c", 32'(if_c.o_grant_index), 0);
    repeat (2) @(negedge clk);
    idle_all();
    rst_n = 1'b1;

    foreach (vecs[n]) begin
      @(negedge clk);
      idle_all();
      case (vecs[n].dut)
        0: begin
          if_a.i_request = vecs[n].req; if_a.i_weight = vecs[n].weight;
          if_a.i_free = vecs[n].free;
        end
        1: begin
          if_b.i_request = vecs[n].req[1:0]; if_b.i_weight = vecs[n].weight[7:0];
          if_b.i_free = vecs[n].free[1:0];
        end
        default: begin
          if_c.i_request = vecs[n].req; if_c.i_weight = vecs[n].weight;
          if_c.i_free = vecs[n].free;
        end
      endcase
      #1;
      case (vecs[n].dut)
        0:       begin act_g = if_a.o_grant; act_b = if_a.o_busy;
                       act_i = 32'(if_a.o_grant_index); end
        1:       begin act_g = {2'b00, if_b.o_grant}; act_b = if_b.o_busy;
                       act_i = 32'(if_b.o_grant_index); end
        default: begin act_g = if_c.o_grant; act_b = if_c.o_busy;
                       act_i = 32'(if_c.o_grant_index); end
      endcase
      check($sformatf("%s[%0d] grant", vecs[n].name, n), 32'(act_g), 32'(vecs[n].exp_grant));
      check($sformatf("%s[%0d] busy", vecs[n].name, n), 32'(act_b), 32'(vecs[n].exp_busy));
      check($sformatf("%s[%0d] index", vecs[n].name, n), act_i, idx_of(vecs[n].exp_grant));
    end

    // Test 6: reset while req1 holds the grant with credit left
    @(negedge clk);
    idle_all();
    if_c.i_weight = 16'h1131;
    if_c.i_request = 4'b0010;
    #1 check("mid_grab", 32'(if_c.o_grant), 32'b0010);
    @(negedge clk);
    if_c.i_request = 4'b1111;
    #1 check("mid_hold_grant", 32'(if_c.o_grant), 32'b0010);
    check("mid_hold_busy", 32'(if_c.o_busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_grant", 32'(if_c.o_grant), 0);
    check("mid_rst_busy", 32'(if_c.o_busy), 0);
    check("mid_rst_index", 32'(if_c.o_grant_index), 0);
    @(negedge clk);
    rst_n = 1'b1;
    if_c.i_weight = 16'h1111;
    #1 check("post_rst_grant", 32'(if_c.o_grant), 32'b0001);
    check("post_rst_busy", 32'(if_c.o_busy), 0);

    // Fresh reset before random traffic
    @(negedge clk);
    idle_all();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = 3; m_credit[d] = 0; m_busy[d] = 1'b0;
    end

    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      r = 4'($urandom_range(0, 15));
      f = 4'($urandom_range(0, 15));
      if_a.i_request = ($urandom_range(0, 7) == 0) ? 4'b0000 : r;
      if_a.i_free = f;
      if ($urandom_range(0, 7) == 0) if_a.i_weight = 16'($urandom());
      r = 4'($urandom_range(0, 15));
      f = 4'($urandom_range(0, 15));
      if_c.i_request = ($urandom_range(0, 5) == 0) ? 4'b0000 : r;
      if_c.i_free = ($urandom_range(0, 2) == 0) ? f : 4'b0000;
      if ($urandom_range(0, 7) == 0) if_c.i_weight = 16'($urandom());
      #1;
      model_step(0, 1'b0, if_a.i_request, if_a.i_weight, if_a.i_free, eg, eb);
      check($sformatf("rnd_a[%0d] grant", n), 32'(if_a.o_grant), 32'(eg));
      check($sformatf("rnd_a[%0d] index", n), 32'(if_a.o_grant_index), idx_of(eg));
      check($sformatf("rnd_a[%0d] busy", n), 32'(if_a.o_busy), 32'(eb));
      model_step(1, 1'b1, if_c.i_request, if_c.i_weight, if_c.i_free, eg, eb);
      check($sformatf("rnd_c[%0d] grant", n), 32'(if_c.o_grant), 32'(eg));
      check($sformatf("rnd_c[%0d] index", n), 32'(if_c.o_grant_index), idx_of(eg));
      check($sformatf("rnd_c[%0d] busy", n), 32'(if_c.o_busy), 32'(eb));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
